// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver:
// frame state encoding, frame geometry and line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_state_t;

    localparam int         UART_DATA_BITS = 8;
    localparam logic [7:0] UART_MIN_RATIO = 8'd4;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    // Below 4 clocks per bit the half-bit start qualification collapses to nothing.
    function automatic logic [7:0] clamp_ratio(input logic [7:0] ratio);
        return (ratio < UART_MIN_RATIO) ? UART_MIN_RATIO : ratio;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for an asynchronous input with a falling-edge flag.
// Flops reset to the idle line level so reset release never fakes an edge.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic fall
);

    localparam int DEPTH = (STAGES < 2) ? 2 : STAGES;

    logic [DEPTH-1:0] stages;
    logic             prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= {DEPTH{LINE_IDLE}};
            prev   <= LINE_IDLE;
        end else begin
            stages <= {stages[DEPTH-2:0], async_in};
            prev   <= stages[DEPTH-1];
        end
    end

    assign sync_out = stages[DEPTH-1];
    assign fall     = prev & ~stages[DEPTH-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, mid-bit sampling at a ratio captured per frame,
// one-cycle strobes for a good byte or a framing error.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_BITS   = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [7:0]           clk_ratio,
    output logic                 rx_active,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_err
);

    localparam int             IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic rx_s;
    logic rx_fall;

    uart_state_t          state, state_d;
    logic [7:0]           cnt, cnt_d;
    logic [7:0]           ratio_q, ratio_d;
    logic [7:0]           half_q, half_d;
    logic [IDX_W-1:0]     bit_idx, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_d;
    logic                 data_valid_d;
    logic                 frame_err_d;
    logic [7:0]           target;
    logic                 tick;

    uart_rx_sync #(
        .STAGES   (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (rx),
        .sync_out (rx_s),
        .fall     (rx_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ratio_q    <= UART_MIN_RATIO;
            half_q     <= '0;
            bit_idx    <= '0;
            shift_q    <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            ratio_q    <= ratio_d;
            half_q     <= half_d;
            bit_idx    <= bit_idx_d;
            shift_q    <= shift_d;
            data       <= data_d;
            data_valid <= data_valid_d;
            frame_err  <= frame_err_d;
        end
    end

    // The start bit is qualified after half a bit; every later sample is a full bit on.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt + 8'd1;
        ratio_d      = ratio_q;
        half_d       = half_q;
        bit_idx_d    = bit_idx;
        shift_d      = shift_q;
        data_d       = data;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        target       = (state == START) ? half_q : ratio_q;
        tick         = (cnt == (target - 8'd1));

        case (state)
            IDLE: begin
                cnt_d = '0;
                if (rx_fall) begin
                    ratio_d = clamp_ratio(clk_ratio);
                    half_d  = clamp_ratio(clk_ratio) >> 1;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    cnt_d = '0;
                    if (rx_s == LINE_START) begin
                        bit_idx_d = '0;
                        state_d   = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d            = '0;
                    shift_d[bit_idx] = rx_s;
                    if (bit_idx == LAST_IDX) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    cnt_d = '0;
                    if (rx_s == LINE_STOP) begin
                        data_d       = shift_q;
                        data_valid_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end
            end
            // A held-low line (break) must release before a new start can be seen.
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s == LINE_IDLE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign rx_active = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomised and directed bench for uart_rx: a serial-line driver feeds frames
// and queues the expected byte/error; a monitor pops and compares on each strobe.
`timescale 1ns/100ps
module tb_uart_rx;

    localparam int SYNC_STAGES = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] clk_ratio = 8'd100;
    logic       rx_active;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;

    uart_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .DATA_BITS   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .clk_ratio  (clk_ratio),
        .rx_active  (rx_active),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err)
    );

    always #0.5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] value;
        int         start_cycle;
        int         latency;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_good = 8'h00;

    task automatic checkOutput(input string name, input bit ok, input int actual, input int required);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d required %0d (cycle %0d)", name, actual, required, cycle);
        end
    endtask

    // Drives one 8N1 frame bit by bit with a fixed bit period, starting at a negedge.
    // reset_bit >= 0 pulses rst in the middle of that data bit (frame aborted, nothing expected).
    // change_bit >= 0 rewrites clk_ratio in the middle of that data bit.
    task automatic applyStimulus(input logic [7:0] value, input int period, input logic [7:0] ratio_setting,
                                 input bit stop_level, input int reset_bit, input int change_bit,
                                 input logic [7:0] new_ratio);
        exp_t e;
        int   eff;
        eff           = (ratio_setting < 8'd4) ? 4 : int'(ratio_setting);
        clk_ratio     = ratio_setting;
        rx            = 1'b0;
        e.start_cycle = cycle;
        e.latency     = SYNC_STAGES + 1 + eff / 2 + 9 * eff;
        if (reset_bit < 0) begin
            e.is_err = !stop_level;
            e.value  = stop_level ? value : last_good;
            if (stop_level) last_good = value;
            exp_q.push_back(e);
        end
        repeat (period) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = value[i];
            if (i == reset_bit || i == change_bit) begin
                repeat (period / 2) @(negedge clk);
                if (i == change_bit) begin
                    clk_ratio = new_ratio;
                    repeat (period - period / 2) @(negedge clk);
                end else begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    last_good = 8'h00;
                    checkOutput("reset_midframe_data", data == 8'h00, data, 0);
                    checkOutput("reset_midframe_strobes", {data_valid, frame_err, rx_active} == 3'b000,
                                {data_valid, frame_err, rx_active}, 0);
                    repeat (period - period / 2 - 1) @(negedge clk);
                end
            end else begin
                repeat (period) @(negedge clk);
            end
        end
        rx = stop_level;
        repeat (period) @(negedge clk);
    endtask

    // Scoreboard monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (!rst && (data_valid || frame_err)) begin
            checkOutput("strobe_exclusive", !(data_valid && frame_err), int'(frame_err), 0);
            checkOutput("strobe_expected", exp_q.size() != 0, exp_q.size(), 1);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                lat = cycle - e.start_cycle;
                checkOutput("strobe_kind", frame_err == e.is_err, int'(frame_err), int'(e.is_err));
                checkOutput("data", data == e.value, data, e.value);
                checkOutput("latency", (lat >= e.latency - 2) && (lat <= e.latency + 2), lat, e.latency);
            end
        end
    end

    initial begin
        int         active_cnt;
        logic [7:0] bytes[4];
        logic [7:0] v;
        int         p;

        // Outputs must stay at reset values while rst is held, whatever the line does.
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            checkOutput("reset_data", data == 8'h00, data, 0);
            checkOutput("reset_strobes", {data_valid, frame_err, rx_active} == 3'b000,
                        {data_valid, frame_err, rx_active}, 0);
            rx = 1'($urandom & 1);
            @(negedge clk);
        end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        bytes[0] = 8'h01; bytes[1] = 8'h55; bytes[2] = 8'h99; bytes[3] = 8'hED;
        for (int i = 0; i < 4; i++) applyStimulus(bytes[i], 100, 8'h64, 1'b1, -1, -1, 8'h00);
        repeat (20) @(negedge clk);

        // Short low pulse: start qualification must reject it after about half a bit.
        clk_ratio  = 8'd100;
        active_cnt = 0;
        rx         = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (i == 20) rx = 1'b1;
            if (rx_active) active_cnt++;
            @(negedge clk);
        end
        checkOutput("glitch_active_len", (active_cnt >= 48) && (active_cnt <= 52), active_cnt, 50);
        checkOutput("glitch_data_held", data == last_good, data, last_good);

        // Stop bit low, then a long break; the receiver must wait for the line to rise.
        applyStimulus(8'hA5, 100, 8'd100, 1'b0, -1, -1, 8'h00);
        repeat (300) @(negedge clk);
        checkOutput("break_active", rx_active == 1'b1, int'(rx_active), 1);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("break_released", rx_active == 1'b0, int'(rx_active), 0);
        repeat (20) @(negedge clk);
        applyStimulus(8'h3C, 100, 8'd100, 1'b1, -1, -1, 8'h00);
        repeat (20) @(negedge clk);

        applyStimulus(8'hFF, 100, 8'd100, 1'b1, 4, -1, 8'h00);
        repeat (20) @(negedge clk);
        applyStimulus(8'h12, 100, 8'd100, 1'b1, -1, -1, 8'h00);
        repeat (20) @(negedge clk);

        // Ratio below the minimum runs at 4; a mid-frame ratio change is ignored.
        applyStimulus(8'h81, 4, 8'd2, 1'b1, -1, -1, 8'h00);
        applyStimulus(8'hC3, 4, 8'd2, 1'b1, -1, 3, 8'h10);
        repeat (10) @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            v = 8'($urandom);
            p = $urandom_range(8, 40);
            applyStimulus(v, p, 8'(p), 1'b1, -1, -1, 8'h00);
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end

        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (50) @(negedge clk);
        checkOutput("scoreboard_drained", exp_q.size() == 0, exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Asynchronous serial receiver. It is the downstream stage that consumes the `tx` line produced by `uart_tx`. The frame format is the same as `uart_tx`: 1 start bit (low), 8 data bits LSB-first, 1 stop bit (high), no parity. The bit period is `clk_ratio` clocks. The block synchronises the line, samples each bit at mid-period, and presents each received byte with a one-cycle valid strobe. It flags frame errors.

Parameters:
- SYNC_STAGES, 2, number of flops in the `rx` input synchroniser (min 2).
- DATA_BITS, 8, data bits per frame. Fixed at 8 for this revision; width of `data`.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- rx  input  1  serial line, asynchronous to `clk`; idles high
- clk_ratio  input  8  clocks per bit; captured at start-bit detection
- rx_active  output  1  high from start detection until frame end or abort
- data  output  8  last correctly received byte; held until the next good frame
- data_valid  output  1  one-cycle strobe; `data` is new
- frame_err  output  1  one-cycle strobe; stop bit sampled low

Behaviour:
- Reset (synchronous, `rst`=1 at a `clk` edge):
  - `data`=0x00, `data_valid`=0, `frame_err`=0, `rx_active`=0.
  - State=IDLE, counters=0.
  - Synchroniser flops reset to 1 (idle line).
  - Reset mid-frame aborts the frame immediately; no strobe is produced.
- Synchroniser: `rx` passes through SYNC_STAGES flops, giving `rx_s`. A falling edge is detected when the previous `rx_s` is 1 and the current `rx_s` is 0.
- Ratio capture:
  - `ratio_q` = `clk_ratio`, latched on start detection.
  - Values below 4 are clamped to 4.
  - Changes to `clk_ratio` mid-frame are ignored.
- Bit counter: counts `clk_ratio` clocks per bit. Sample point is where the counter reaches its terminal value.
- States:
  - IDLE: `rx_active`=0. Falling edge on `rx_s` -> START, load `half` = `ratio_q`>>1, `rx_active`=1 from the next cycle.
  - START: count `half` clocks, then sample.
    - `rx_s`=0 -> DATA, bit index 0.
    - `rx_s`=1 -> IDLE (glitch reject, no strobe, `rx_active` drops).
  - DATA: every `ratio_q` clocks, sample `rx_s` into shift register bit[index], LSB first. After index 7 -> STOP.
  - STOP: after `ratio_q` clocks, sample.
    - `rx_s`=1: `data` <= shift reg and `data_valid`=1 for exactly the next cycle, then -> IDLE.
    - `rx_s`=0: `frame_err`=1 for exactly one cycle, `data` unchanged, -> WAIT_HIGH.
  - WAIT_HIGH: remain (`rx_active`=1) until `rx_s`=1, then -> IDLE. This prevents a break condition from re-triggering.
- `rx_active` falls in the same cycle that `data_valid` or `frame_err` rises (IDLE entry).
- Back-to-back frames: a new start edge is accepted on the first cycle IDLE is reached. Zero idle time after the stop-bit mid-sample is tolerated because the edge arrives half a bit later.
- Detection latency: start edge on `rx` -> START entry is SYNC_STAGES+1 cycles.
- Strobe timing: strobe at start-edge + SYNC_STAGES+1 + `half` + 9·`ratio_q` + 1 cycles (±1).
- `data_valid` and `frame_err` are never high together.

Decomposition:
- Package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP, WAIT_HIGH)
  - `UART_DATA_BITS`=8
  - `UART_MIN_RATIO`=4
  - line idle/start/stop level constants
  - `uart_tx` and `uart_rx` both import it.
- Sub-module `uart_rx_sync`: SYNC_STAGES-deep synchroniser with falling-edge detect output. It is reusable for other async inputs.

Test Plan:
- Loopback from `uart_tx` (`clk_ratio`=0x64, 1 ns clk), bytes 0x01, 0x55, 0x99, 0xED sent back-to-back:
  - exactly 4 `data_valid` pulses, with `data` equal to each byte in order;
  - `frame_err` never asserts;
  - each pulse arrives ~953±2 cycles after its start edge.
- Glitch: drive `rx` low for 20 cycles then high, `clk_ratio`=100 -> `rx_active` pulses for about `half` cycles, then falls; no `data_valid`; `data` stays at the previous value.
- Framing error: 0xA5 with stop bit forced low, `rx` held low 300 more cycles then released:
  - `frame_err` pulses once;
  - `data` is unchanged;
  - `rx_active` stays high until `rx` returns high, then 0x3C is received correctly.
- Reset mid-frame: assert `rst` for 1 cycle during data bit 4 of 0xFF:
  - all outputs return to 0 the next cycle, no strobe;
  - the following frame 0x12 is received correctly.
- Ratio clamp/change: `clk_ratio`=2 with the stimulus bit period at 4 clocks, sending 0x81 -> received 0x81. Then `clk_ratio` is changed to 0x10 mid-frame -> the frame still decodes at ratio 4.
- Reset values: with `rst` held high, `rx` toggling -> `data`=0x00 and `data_valid`=`frame_err`=`rx_active`=0 on every cycle.
